pipeline_ctrl: RTL and testbench

PIPELINE_CTRL -- requirements
Module: pipeline_ctrl

---
 rtl/pipeline_ctrl_pkg.sv | 34 +++
 rtl/pipeline_ctrl.sv | 149 ++++++++++++++
 tb/tb_pipeline_ctrl.sv | 202 ++++++++++++++++++++
 3 files changed

// File: rtl/pipeline_ctrl_pkg.sv
// Shared definitions for the pipeline hazard/flush controller and the ID-stage decoder.
package pipeline_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_STALL  = 2'd1,
    ST_FREEZE = 2'd2
  } pipe_state_e;

  localparam logic [1:0] PC_SEL_SEQ = 2'b00;
  localparam logic [1:0] PC_SEL_JMP = 2'b01;
  localparam logic [1:0] PC_SEL_BR  = 2'b10;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2b;

  // Decoder helpers: which opcodes read rt, load from memory, or jump.
  function automatic logic op_reads_rt(input logic [5:0] op);
    return (op == OP_RTYPE) || (op == OP_SW) || (op == OP_BEQ) || (op == OP_BNE);
  endfunction

  function automatic logic op_is_load(input logic [5:0] op);
    return op == OP_LW;
  endfunction

  function automatic logic op_is_jump(input logic [5:0] op);
    return op == OP_J;
  endfunction

endpackage

// File: rtl/pipeline_ctrl.sv
// Five-stage pipeline controller: load-use stalls, branch/jump flushes, memory freeze.
// Optional performance counters are built when PIPE_CTRL_PERF_EN is defined.
module pipeline_ctrl
  import pipeline_ctrl_pkg::*;
#(
  parameter int STALL_CYC = 1,
  parameter int CNT_W     = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [4:0]       if_id_rs_i,
  input  logic [4:0]       if_id_rt_i,
  input  logic             if_id_use_rt_i,
  input  logic             id_ex_memread_i,
  input  logic [4:0]       id_ex_rt_i,
  input  logic             jump_i,
  input  logic             branch_taken_i,
  input  logic             dmem_busy_i,
  output logic             pc_write_o,
  output logic             if_id_write_o,
  output logic             if_id_flush_o,
  output logic             id_ex_flush_o,
  output logic             ex_mem_flush_o,
  output logic [1:0]       pc_sel_o,
  output logic [CNT_W-1:0] stall_cnt_o,
  output logic [CNT_W-1:0] flush_cnt_o
);

  localparam logic [1:0] BCNT_INIT = 2'(STALL_CYC - 1);

  pipe_state_e state_q, state_d, cur_st;
  logic [1:0]  bcnt_q, bcnt_d;
  logic        hazard;
  logic        bubble;

  assign hazard = id_ex_memread_i && (id_ex_rt_i != 5'd0) &&
                  ((id_ex_rt_i == if_id_rs_i) ||
                   (if_id_use_rt_i && (id_ex_rt_i == if_id_rt_i)));

  // FREEZE keeps bcnt untouched, and bcnt is non-zero only while stalling,
  // so the interrupted state is recovered from bcnt when the freeze lifts.
  always_comb begin
    cur_st = state_q;
    if (state_q == ST_FREEZE) cur_st = (bcnt_q != 2'd0) ? ST_STALL : ST_RUN;
  end

  // NOTE: every output and next-state value gets a default first so no latch is inferred.
  always_comb begin
    state_d        = state_q;
    bcnt_d         = bcnt_q;
    bubble         = 1'b0;
    pc_write_o     = 1'b1;
    if_id_write_o  = 1'b1;
    if_id_flush_o  = 1'b0;
    id_ex_flush_o  = 1'b0;
    ex_mem_flush_o = 1'b0;
    pc_sel_o       = PC_SEL_SEQ;

    if (rst_i) begin
      pc_write_o     = 1'b0;
      if_id_write_o  = 1'b0;
      if_id_flush_o  = 1'b1;
      id_ex_flush_o  = 1'b1;
      ex_mem_flush_o = 1'b1;
      state_d        = ST_RUN;
      bcnt_d         = 2'd0;
    end else if (dmem_busy_i) begin
      pc_write_o    = 1'b0;
      if_id_write_o = 1'b0;
      state_d       = ST_FREEZE;
    end else if (branch_taken_i) begin
      pc_sel_o       = PC_SEL_BR;
      if_id_flush_o  = 1'b1;
      id_ex_flush_o  = 1'b1;
      ex_mem_flush_o = 1'b1;
      state_d        = ST_RUN;
      bcnt_d         = 2'd0;
    end else if (jump_i) begin
      pc_sel_o      = PC_SEL_JMP;
      if_id_flush_o = 1'b1;
      state_d       = ST_RUN;
      bcnt_d        = 2'd0;
    end else if (cur_st == ST_RUN && hazard) begin
      bubble = 1'b1;
      if (STALL_CYC > 1) begin
        state_d = ST_STALL;
        bcnt_d  = BCNT_INIT;
      end else begin
        state_d = ST_RUN;
      end
    end else if (cur_st == ST_STALL) begin
      bubble  = 1'b1;
      bcnt_d  = bcnt_q - 2'd1;
      state_d = (bcnt_q == 2'd1) ? ST_RUN : ST_STALL;
    end else begin
      state_d = ST_RUN;
    end

    if (bubble) begin
      pc_write_o    = 1'b0;
      if_id_write_o = 1'b0;
      id_ex_flush_o = 1'b1;
    end
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= ST_RUN;
      bcnt_q  <= 2'd0;
    end else begin
      state_q <= state_d;
      bcnt_q  <= bcnt_d;
    end
  end

`ifdef PIPE_CTRL_PERF_EN
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;
  logic             br_flush;

  assign br_flush = !rst_i && !dmem_busy_i && branch_taken_i;

  // Both counters saturate at all-ones; freeze cycles produce no events.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (bubble && (stall_cnt_q != '1))   stall_cnt_d = stall_cnt_q + 1'b1;
    if (br_flush && (flush_cnt_q != '1)) flush_cnt_d = flush_cnt_q + 1'b1;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign stall_cnt_o = stall_cnt_q;
  assign flush_cnt_o = flush_cnt_q;
`else
  assign stall_cnt_o = '0;
  assign flush_cnt_o = '0;
`endif

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Directed bench for pipeline_ctrl: three instances at STALL_CYC = 1, 2, 3 share one stimulus.
// Output vectors are packed {pc_write, if_id_write, if_id_flush, id_ex_flush, ex_mem_flush, pc_sel[1:0]}.
module tb_pipeline_ctrl;

  localparam logic [6:0] RUN_O = 7'b1100000;
  localparam logic [6:0] BUB_O = 7'b0001000;
  localparam logic [6:0] FRZ_O = 7'b0000000;
  localparam logic [6:0] RST_O = 7'b0011100;
  localparam logic [6:0] BR_O  = 7'b1111110;
  localparam logic [6:0] JMP_O = 7'b1110001;

`ifdef PIPE_CTRL_PERF_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic [4:0] rs, rt, ex_rt;
  logic       use_rt, memread, jump, branch, busy;

  logic [6:0]  o1, o2, o3;
  logic [15:0] sc1, fc1, sc2, fc2, sc3, fc3;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  pipeline_ctrl #(.STALL_CYC(1), .CNT_W(16)) u_dut1 (
    .clk_i(clk), .rst_i(rst), .if_id_rs_i(rs), .if_id_rt_i(rt), .if_id_use_rt_i(use_rt),
    .id_ex_memread_i(memread), .id_ex_rt_i(ex_rt), .jump_i(jump), .branch_taken_i(branch),
    .dmem_busy_i(busy), .pc_write_o(o1[6]), .if_id_write_o(o1[5]), .if_id_flush_o(o1[4]),
    .id_ex_flush_o(o1[3]), .ex_mem_flush_o(o1[2]), .pc_sel_o(o1[1:0]),
    .stall_cnt_o(sc1), .flush_cnt_o(fc1));

  pipeline_ctrl #(.STALL_CYC(2), .CNT_W(16)) u_dut2 (
    .clk_i(clk), .rst_i(rst), .if_id_rs_i(rs), .if_id_rt_i(rt), .if_id_use_rt_i(use_rt),
    .id_ex_memread_i(memread), .id_ex_rt_i(ex_rt), .jump_i(jump), .branch_taken_i(branch),
    .dmem_busy_i(busy), .pc_write_o(o2[6]), .if_id_write_o(o2[5]), .if_id_flush_o(o2[4]),
    .id_ex_flush_o(o2[3]), .ex_mem_flush_o(o2[2]), .pc_sel_o(o2[1:0]),
    .stall_cnt_o(sc2), .flush_cnt_o(fc2));

  pipeline_ctrl #(.STALL_CYC(3), .CNT_W(16)) u_dut3 (
    .clk_i(clk), .rst_i(rst), .if_id_rs_i(rs), .if_id_rt_i(rt), .if_id_use_rt_i(use_rt),
    .id_ex_memread_i(memread), .id_ex_rt_i(ex_rt), .jump_i(jump), .branch_taken_i(branch),
    .dmem_busy_i(busy), .pc_write_o(o3[6]), .if_id_write_o(o3[5]), .if_id_flush_o(o3[4]),
    .id_ex_flush_o(o3[3]), .ex_mem_flush_o(o3[2]), .pc_sel_o(o3[1:0]),
    .stall_cnt_o(sc3), .flush_cnt_o(fc3));

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance one clock; inputs change 1 ns after the rising edge.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    rs = 5'd0; rt = 5'd0; ex_rt = 5'd0; use_rt = 1'b0;
    memread = 1'b0; jump = 1'b0; branch = 1'b0; busy = 1'b0;
  endtask

  // lw r3 in EX, ID reads rs = r3.
  task automatic hazard_on();
    memread = 1'b1; ex_rt = 5'd3; rs = 5'd3; rt = 5'd7; use_rt = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    #1;
  endtask

  initial begin
    rst = 1'b1;
    idle();
    #1;
    // Reset state
    check("rst_outputs", {9'd0, o3}, {9'd0, RST_O});
    cyc();
    cyc();
    rst = 1'b0;
    #1;
    check("post_rst_run", {9'd0, o3}, {9'd0, RUN_O});
    check("post_rst_stall_cnt", sc3, 16'd0);
    check("post_rst_flush_cnt", fc3, 16'd0);

    // Single-bubble load-use stall
    hazard_on(); #1;
    check("sc1_bubble", {9'd0, o1}, {9'd0, BUB_O});
    cyc();
    idle(); #1;
    check("sc1_resume", {9'd0, o1}, {9'd0, RUN_O});

    // Three-bubble stall with a two-cycle freeze in the middle
    do_reset();
    hazard_on(); #1;
    check("sc3_bubble1", {9'd0, o3}, {9'd0, BUB_O});
    cyc();
    idle(); busy = 1'b1; #1;
    check("sc3_freeze1", {9'd0, o3}, {9'd0, FRZ_O});
    cyc(); #1;
    check("sc3_freeze2", {9'd0, o3}, {9'd0, FRZ_O});
    cyc();
    busy = 1'b0; #1;
    check("sc3_bubble2", {9'd0, o3}, {9'd0, BUB_O});
    cyc(); #1;
    check("sc3_bubble3", {9'd0, o3}, {9'd0, BUB_O});
    cyc(); #1;
    check("sc3_resume", {9'd0, o3}, {9'd0, RUN_O});
    check("sc3_stall_cnt", sc3, PERF ? 16'd3 : 16'd0);

    // Branch taken during STALL cancels remaining bubbles
    do_reset();
    hazard_on(); #1;
    check("br_bubble1", {9'd0, o3}, {9'd0, BUB_O});
    cyc();
    idle(); branch = 1'b1; #1;
    check("br_in_stall", {9'd0, o3}, {9'd0, BR_O});
    cyc();
    branch = 1'b0; #1;
    check("br_next_run", {9'd0, o3}, {9'd0, RUN_O});
    cyc(); #1;
    check("br_no_leftover", {9'd0, o3}, {9'd0, RUN_O});
    check("br_flush_cnt", fc3, PERF ? 16'd1 : 16'd0);

    // Jump outranks a simultaneous hazard
    hazard_on(); jump = 1'b1; #1;
    check("jmp_over_hazard", {9'd0, o3}, {9'd0, JMP_O});
    cyc();
    idle(); #1;
    check("jmp_no_stall", {9'd0, o3}, {9'd0, RUN_O});

    // lw to r0 never stalls; rt path depends on if_id_use_rt_i
    memread = 1'b1; ex_rt = 5'd0; rs = 5'd0; rt = 5'd0; use_rt = 1'b1; #1;
    check("r0_no_stall", {9'd0, o3}, {9'd0, RUN_O});
    ex_rt = 5'd5; rs = 5'd1; rt = 5'd5; use_rt = 1'b0; #1;
    check("rt_unused_no_stall", {9'd0, o3}, {9'd0, RUN_O});
    use_rt = 1'b1; #1;
    check("rt_hazard", {9'd0, o3}, {9'd0, BUB_O});
    cyc();
    idle(); #1;
    check("rt_stall_cont", {9'd0, o3}, {9'd0, BUB_O});
    cyc();

    // Reset asserted mid-STALL
    rst = 1'b1; #1;
    check("rst_mid_stall", {9'd0, o3}, {9'd0, RST_O});
    cyc();
    rst = 1'b0; #1;
    check("rst_stall_run", {9'd0, o3}, {9'd0, RUN_O});
    check("rst_stall_cnt_clr", sc3, 16'd0);
    check("rst_flush_cnt_clr", fc3, 16'd0);
    cyc(); #1;
    check("rst_stall_no_leftover", {9'd0, o3}, {9'd0, RUN_O});

    // Reset asserted mid-FREEZE (busy still high)
    hazard_on(); #1;
    cyc();
    idle(); busy = 1'b1; #1;
    check("frz_before_rst", {9'd0, o3}, {9'd0, FRZ_O});
    cyc();
    rst = 1'b1; #1;
    check("rst_over_busy", {9'd0, o3}, {9'd0, RST_O});
    cyc();
    rst = 1'b0; busy = 1'b0; #1;
    check("rst_frz_run", {9'd0, o3}, {9'd0, RUN_O});

    // Five hazards at STALL_CYC=2 then three branches
    do_reset();
    for (int i = 0; i < 5; i++) begin
      hazard_on(); #1;
      check("sc2_bubble_a", {9'd0, o2}, {9'd0, BUB_O});
      cyc();
      idle(); #1;
      check("sc2_bubble_b", {9'd0, o2}, {9'd0, BUB_O});
      cyc(); #1;
      check("sc2_run", {9'd0, o2}, {9'd0, RUN_O});
    end
    for (int i = 0; i < 3; i++) begin
      branch = 1'b1; #1;
      check("sc2_branch", {9'd0, o2}, {9'd0, BR_O});
      cyc();
      branch = 1'b0; #1;
    end
    check("perf_stall_cnt", sc2, PERF ? 16'd10 : 16'd0);
    check("perf_flush_cnt", fc2, PERF ? 16'd3 : 16'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
